// File: rtl/sd_block_streamer.sv
// sd_block_streamer: fetches consecutive SD-card blocks into a two-bank
// ping-pong byte buffer and unpacks them into 16-bit little-endian stereo
// sample pairs on request from the S/PDIF transmitter.
module sd_block_streamer #(
  parameter logic [31:0] Start_Block = 32'd0,
  parameter logic [31:0] Block_Count = 32'd1024
) (
  input  logic        Reset,
  input  logic        Clk,
  input  logic        Enable,
  output logic [31:0] Block,
  output logic        Read,
  input  logic        Busy,
  input  logic [8:0]  Address,
  input  logic [7:0]  Data,
  input  logic        Write_Enable,
  input  logic        Card_Error,
  input  logic        Sample_Request,
  output logic [15:0] Left,
  output logic [15:0] Right,
  output logic        Sample_Valid,
  output logic        Underrun,
  output logic        Error
);

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQUEST,
    F_WAIT
  } fetch_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_OUT
  } read_state_t;

  // Fetch side state
  fetch_state_t fetch_state_q, fetch_state_d;
  logic [31:0]  block_q, block_d;
  logic         read_q, read_d;
  logic         wr_bank_q, wr_bank_d;
  logic [31:0]  block_index_q, block_index_d;
  logic         error_q, error_d;
  logic         full_set;

  // Shared bank occupancy
  logic [1:0]   full_q, full_d;

  // Reader side state
  read_state_t  rd_state_q, rd_state_d;
  logic         hit_q, hit_d;
  logic [1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [6:0]   sample_index_q, sample_index_d;
  logic         rd_bank_q, rd_bank_d;
  logic [7:0]   l_lo_q, l_lo_d;
  logic [7:0]   l_hi_q, l_hi_d;
  logic [7:0]   r_lo_q, r_lo_d;
  logic [15:0]  left_q, left_d;
  logic [15:0]  right_q, right_d;
  logic         sample_valid_q, sample_valid_d;
  logic         underrun_q, underrun_d;
  logic         full_clr;

  // Buffer RAM
  logic [7:0]   mem [0:1023];
  logic [7:0]   ram_q;
  logic [9:0]   rd_addr;

  assign rd_addr = {rd_bank_q, sample_index_q, fetch_cnt_q};

  // Ping-pong buffer: the reader always writes into the bank being filled, reads are registered
  always_ff @(posedge Clk) begin
    if (Write_Enable) begin
      mem[{wr_bank_q, Address}] <= Data;
    end
    ram_q <= mem[rd_addr];
  end

  // Fetch FSM: request a block when the fill bank is empty, then wait for the reader to finish it
  always_comb begin
    fetch_state_d = fetch_state_q;
    block_d       = block_q;
    read_d        = read_q;
    wr_bank_d     = wr_bank_q;
    block_index_d = block_index_q;
    error_d       = error_q | Card_Error;
    full_set      = 1'b0;

    if (Card_Error) begin
      fetch_state_d = F_IDLE;
      read_d        = 1'b0;
    end else begin
      case (fetch_state_q)
        F_IDLE: begin
          if (Enable && !Busy && !full_q[wr_bank_q] && !error_q) begin
            block_d       = Start_Block + block_index_q;
            read_d        = 1'b1;
            fetch_state_d = F_REQUEST;
          end
        end
        F_REQUEST: begin
          if (Busy) begin
            read_d        = 1'b0;
            fetch_state_d = F_WAIT;
          end
        end
        F_WAIT: begin
          if (!Busy) begin
            full_set  = 1'b1;
            wr_bank_d = ~wr_bank_q;
            if (block_index_q == Block_Count - 32'd1) begin
              block_index_d = 32'd0;
            end else begin
              block_index_d = block_index_q + 32'd1;
            end
            fetch_state_d = F_IDLE;
          end
        end
        default: begin
          fetch_state_d = F_IDLE;
        end
      endcase
    end
  end

  // Reader FSM: read four bytes of the current pair, then present the sample or an underrun
  always_comb begin
    rd_state_d     = rd_state_q;
    hit_d          = hit_q;
    fetch_cnt_d    = fetch_cnt_q;
    sample_index_d = sample_index_q;
    rd_bank_d      = rd_bank_q;
    l_lo_d         = l_lo_q;
    l_hi_d         = l_hi_q;
    r_lo_d         = r_lo_q;
    left_d         = left_q;
    right_d        = right_q;
    sample_valid_d = 1'b0;
    underrun_d     = 1'b0;
    full_clr       = 1'b0;

    case (rd_state_q)
      R_IDLE: begin
        if (Sample_Request) begin
          hit_d       = full_q[rd_bank_q];
          fetch_cnt_d = 2'd0;
          rd_state_d  = R_FETCH;
        end
      end
      R_FETCH: begin
        fetch_cnt_d = fetch_cnt_q + 2'd1;
        case (fetch_cnt_q)
          2'd1:    l_lo_d = ram_q;
          2'd2:    l_hi_d = ram_q;
          2'd3:    r_lo_d = ram_q;
          default: ;
        endcase
        if (fetch_cnt_q == 2'd3) begin
          rd_state_d = R_OUT;
        end
      end
      R_OUT: begin
        sample_valid_d = 1'b1;
        rd_state_d     = R_IDLE;
        if (hit_q) begin
          left_d         = {l_hi_q, l_lo_q};
          right_d        = {ram_q, r_lo_q};
          sample_index_d = sample_index_q + 7'd1;
          if (sample_index_q == 7'd127) begin
            full_clr  = 1'b1;
            rd_bank_d = ~rd_bank_q;
          end
        end else begin
          left_d     = 16'd0;
          right_d    = 16'd0;
          underrun_d = 1'b1;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
      end
    endcase
  end

  // Bank flags: set and clear always target different banks, so both apply independently
  always_comb begin
    full_d = full_q;
    if (full_set) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (full_clr) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  // State registers for both FSMs and the shared flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_state_q  <= F_IDLE;
      block_q        <= 32'd0;
      read_q         <= 1'b0;
      wr_bank_q      <= 1'b0;
      block_index_q  <= 32'd0;
      error_q        <= 1'b0;
      full_q         <= 2'b00;
      rd_state_q     <= R_IDLE;
      hit_q          <= 1'b0;
      fetch_cnt_q    <= 2'd0;
      sample_index_q <= 7'd0;
      rd_bank_q      <= 1'b0;
      l_lo_q         <= 8'd0;
      l_hi_q         <= 8'd0;
      r_lo_q         <= 8'd0;
      left_q         <= 16'd0;
      right_q        <= 16'd0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      fetch_state_q  <= fetch_state_d;
      block_q        <= block_d;
      read_q         <= read_d;
      wr_bank_q      <= wr_bank_d;
      block_index_q  <= block_index_d;
      error_q        <= error_d;
      full_q         <= full_d;
      rd_state_q     <= rd_state_d;
      hit_q          <= hit_d;
      fetch_cnt_q    <= fetch_cnt_d;
      sample_index_q <= sample_index_d;
      rd_bank_q      <= rd_bank_d;
      l_lo_q         <= l_lo_d;
      l_hi_q         <= l_hi_d;
      r_lo_q         <= r_lo_d;
      left_q         <= left_d;
      right_q        <= right_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
    end
  end

  assign Block        = block_q;
  assign Read         = read_q;
  assign Left         = left_q;
  assign Right        = right_q;
  assign Sample_Valid = sample_valid_q;
  assign Underrun     = underrun_q;
  assign Error        = error_q;

endmodule

// File: tb/tb_sd_block_streamer.sv
// Bench for sd_block_streamer: an SD reader model serving ramp blocks,
// a transmitter issuing sample requests, and a behavioural reference model.
module tb_sd_block_streamer;

  localparam int START = 100;
  localparam int COUNT = 2;

  logic        Reset, Clk, Enable, Busy, Write_Enable, Card_Error, Sample_Request;
  logic [8:0]  Address;
  logic [7:0]  Data;
  logic [31:0] Block;
  logic        Read;
  logic [15:0] Left, Right;
  logic        Sample_Valid, Underrun, Error;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit check_en = 0;
  bit sd_on = 0;
  bit sd_active = 0;
  bit sd_in_wait = 0;
  bit err_flag = 0;
  int err_cyc = 0;

  // Reference model state: pending request cycles, full blocks in play order, their ready cycles
  int req_q[$];
  int bank_q[$];
  int ready_q[$];
  int samp_idx = 0;
  int fetches_done = 0;
  int blk_log[$];

  sd_block_streamer #(
    .Start_Block(32'(START)),
    .Block_Count(32'(COUNT))
  ) dut (
    .Reset(Reset),
    .Clk(Clk),
    .Enable(Enable),
    .Block(Block),
    .Read(Read),
    .Busy(Busy),
    .Address(Address),
    .Data(Data),
    .Write_Enable(Write_Enable),
    .Card_Error(Card_Error),
    .Sample_Request(Sample_Request),
    .Left(Left),
    .Right(Right),
    .Sample_Valid(Sample_Valid),
    .Underrun(Underrun),
    .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Cycle number of the interval following each rising edge
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [7:0] rampByte(int n, int k);
    return 8'((k + n) & 255);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One sample request; returns the outputs seen six cycles later
  task automatic applyStimulus(output logic v, output logic [15:0] l, output logic [15:0] r,
                               output logic u);
    int t;
    repeat (2) @(negedge Clk);
    Sample_Request = 1'b1;
    t = cyc;
    req_q.push_back(t);
    @(negedge Clk);
    Sample_Request = 1'b0;
    while (cyc < t + 6) @(negedge Clk);
    v = Sample_Valid;
    l = Left;
    r = Right;
    u = Underrun;
  endtask

  // SD reader model: answers Read with Busy, writes block n byte k = (k+n)&FF, then releases Busy
  initial begin : sd_reader
    int blk;
    int n;
    int delay;
    Busy = 1'b0;
    Write_Enable = 1'b0;
    Address = 9'd0;
    Data = 8'd0;
    forever begin
      @(negedge Clk);
      if (sd_on && Read === 1'b1) begin
        sd_active = 1'b1;
        blk = int'(Block);
        checkOutput("block_number", Block, 32'(START + (fetches_done % COUNT)));
        blk_log.push_back(blk);
        n = blk - START;
        delay = $urandom_range(0, 2);
        repeat (delay) @(negedge Clk);
        checkOutput("read_hold", 32'(Read), 32'd1);
        Busy = 1'b1;
        @(negedge Clk);
        checkOutput("read_fall", 32'(Read), 32'd0);
        sd_in_wait = 1'b1;
        for (int k = 0; k < 512; k++) begin
          if ($urandom_range(0, 7) == 0) begin
            Write_Enable = 1'b0;
            @(negedge Clk);
          end
          Address = 9'(k);
          Data = rampByte(n, k);
          Write_Enable = 1'b1;
          @(negedge Clk);
        end
        Write_Enable = 1'b0;
        Busy = 1'b0;
        if (!err_flag) begin
          bank_q.push_back(n);
          ready_q.push_back(cyc + 1);
          fetches_done++;
        end
        sd_in_wait = 1'b0;
        sd_active = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the reference model
  always @(negedge Clk) begin : compare_proc
    int t;
    int n;
    int s;
    int full_now;
    bit exp_v;
    bit hit;
    bit err_active;
    logic [15:0] el;
    logic [15:0] er;
    logic eu;
    if (check_en) begin
      exp_v = (req_q.size() > 0) && (req_q[0] + 6 == cyc);
      checkOutput("sample_valid", 32'(Sample_Valid), 32'(exp_v));
      if (exp_v) begin
        t = req_q.pop_front();
        hit = (bank_q.size() > 0) && (ready_q[0] <= t);
        if (hit) begin
          n = bank_q[0];
          s = samp_idx;
          el = {rampByte(n, 4 * s + 1), rampByte(n, 4 * s)};
          er = {rampByte(n, 4 * s + 3), rampByte(n, 4 * s + 2)};
          eu = 1'b0;
          samp_idx++;
          if (samp_idx == 128) begin
            samp_idx = 0;
            void'(bank_q.pop_front());
            void'(ready_q.pop_front());
          end
        end else begin
          el = 16'd0;
          er = 16'd0;
          eu = 1'b1;
        end
        checkOutput("left", 32'(Left), 32'(el));
        checkOutput("right", 32'(Right), 32'(er));
        checkOutput("underrun", 32'(Underrun), 32'(eu));
      end else begin
        checkOutput("underrun_idle", 32'(Underrun), 32'd0);
      end
      full_now = 0;
      foreach (ready_q[i]) if (ready_q[i] <= cyc) full_now++;
      err_active = err_flag && (cyc >= err_cyc);
      checkOutput("read_blocked", 32'(Read & ((full_now >= 2) | err_active)), 32'd0);
      checkOutput("error_flag", 32'(Error), 32'(err_active));
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge Clk);
    n_bad++;
    $display("[TB] FAIL watchdog: actual=running required=finished (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : main
    logic v, u;
    logic [15:0] l, r;
    int guard;
    int hits;
    int base_log;
    int t;

    Reset = 1'b1;
    Enable = 1'b0;
    Card_Error = 1'b0;
    Sample_Request = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("rst_read", 32'(Read), 32'd0);
    checkOutput("rst_block", Block, 32'd0);
    checkOutput("rst_left", 32'(Left), 32'd0);
    checkOutput("rst_right", 32'(Right), 32'd0);
    checkOutput("rst_valid", 32'(Sample_Valid), 32'd0);
    checkOutput("rst_underrun", 32'(Underrun), 32'd0);
    checkOutput("rst_error", 32'(Error), 32'd0);
    Reset = 1'b0;
    check_en = 1'b1;

    $display("[TB] requests before any bank is full");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(v, l, r, u);
      checkOutput("early_valid", 32'(v), 32'd1);
      checkOutput("early_left", 32'(l), 32'd0);
      checkOutput("early_right", 32'(r), 32'd0);
      checkOutput("early_underrun", 32'(u), 32'd1);
    end

    $display("[TB] first fetch and first sample");
    Enable = 1'b1;
    sd_on = 1'b1;
    guard = 0;
    while (!(ready_q.size() > 0 && ready_q[0] <= cyc) && guard < 2000) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("first_fill_in_time", 32'(guard < 2000), 32'd1);
    applyStimulus(v, l, r, u);
    checkOutput("first_valid", 32'(v), 32'd1);
    checkOutput("first_left", 32'(l), 32'h0100);
    checkOutput("first_right", 32'(r), 32'h0302);
    checkOutput("first_underrun", 32'(u), 32'd0);

    $display("[TB] both banks full, requests stopped");
    guard = 0;
    while (!(ready_q.size() == 2 && ready_q[1] <= cyc) && guard < 2000) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("both_full_in_time", 32'(guard < 2000), 32'd1);
    repeat (150) @(negedge Clk);
    checkOutput("fetches_while_full", 32'(blk_log.size()), 32'd2);

    $display("[TB] drain bank 0 and cross into bank 1");
    for (int i = 0; i < 127; i++) begin
      applyStimulus(v, l, r, u);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
    applyStimulus(v, l, r, u);
    checkOutput("bank1_left", 32'(l), 32'h0201);
    checkOutput("bank1_right", 32'(r), 32'h0403);
    checkOutput("bank1_underrun", 32'(u), 32'd0);
    guard = 0;
    while (blk_log.size() < 3 && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("refetch_started", 32'(blk_log.size() >= 3), 32'd1);
    if (blk_log.size() >= 3) begin
      checkOutput("block_seq0", 32'(blk_log[0]), 32'd100);
      checkOutput("block_seq1", 32'(blk_log[1]), 32'd101);
      checkOutput("block_seq2", 32'(blk_log[2]), 32'd100);
    end

    $display("[TB] randomized requests");
    for (int i = 0; i < 150; i++) begin
      Enable = ($urandom_range(0, 4) != 0);
      applyStimulus(v, l, r, u);
      repeat ($urandom_range(0, 20)) @(negedge Clk);
    end
    Enable = 1'b1;

    $display("[TB] reset with Read high and reader mid-fetch");
    sd_on = 1'b0;
    @(negedge Clk);
    guard = 0;
    while (sd_active && guard < 1500) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("sd_idle_in_time", 32'(sd_active), 32'd0);
    guard = 0;
    while (Read !== 1'b1 && guard < 400) begin
      applyStimulus(v, l, r, u);
      guard++;
    end
    checkOutput("read_high_before_reset", 32'(Read), 32'd1);
    repeat (2) @(negedge Clk);
    Sample_Request = 1'b1;
    t = cyc;
    @(negedge Clk);
    Sample_Request = 1'b0;
    @(negedge Clk);
    check_en = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("mid_rst_read", 32'(Read), 32'd0);
    checkOutput("mid_rst_block", Block, 32'd0);
    checkOutput("mid_rst_left", 32'(Left), 32'd0);
    checkOutput("mid_rst_right", 32'(Right), 32'd0);
    checkOutput("mid_rst_valid", 32'(Sample_Valid), 32'd0);
    checkOutput("mid_rst_underrun", 32'(Underrun), 32'd0);
    checkOutput("mid_rst_error", 32'(Error), 32'd0);
    Reset = 1'b0;
    while (cyc <= t + 8) begin
      @(negedge Clk);
      checkOutput("no_valid_after_reset", 32'(Sample_Valid), 32'd0);
    end
    req_q.delete();
    bank_q.delete();
    ready_q.delete();
    samp_idx = 0;
    fetches_done = 0;
    base_log = blk_log.size();
    check_en = 1'b1;
    sd_on = 1'b1;

    $display("[TB] card error during the second fetch");
    guard = 0;
    while (!(fetches_done >= 1 && sd_in_wait) && guard < 3000) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("second_fetch_in_time", 32'(guard < 3000), 32'd1);
    repeat ($urandom_range(1, 20)) @(negedge Clk);
    Card_Error = 1'b1;
    err_cyc = cyc + 1;
    err_flag = 1'b1;
    @(negedge Clk);
    Card_Error = 1'b0;
    checkOutput("error_set", 32'(Error), 32'd1);
    checkOutput("error_read_low", 32'(Read), 32'd0);
    hits = 0;
    u = 1'b0;
    for (int i = 0; i < 135; i++) begin
      applyStimulus(v, l, r, u);
      if (!u) hits++;
    end
    checkOutput("hits_after_error", 32'(hits), 32'd128);
    checkOutput("last_is_underrun", 32'(u), 32'd1);
    checkOutput("error_sticky", 32'(Error), 32'd1);
    checkOutput("no_fetch_after_error", 32'(blk_log.size()), 32'(base_log + 2));

    repeat (4) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
